dmem_responder: RTL and testbench

//  Data-side memory responder: target end of the core's load/store request interface.
//  - Accepts one valid/ready request at a time (read or byte-masked write) and services it.
//  - Returns exactly one response per request after a fixed LATENCY.
//  - Sits between the core's load/store path and a word-organised on-chip RAM.

---
 rtl/dmem_responder_pkg.sv | 29 ++
 rtl/dmem_responder_array.sv | 36 +++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// latency bounds and the legal byte-enable patterns used by the optional
// alignment check (DMEM_ALIGN_CHECK_EN).
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 4;

    // Naturally aligned byte, halfword and word lane patterns
    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    function automatic logic be_is_legal(input logic [3:0] be);
        return (be == BE_B0) || (be == BE_B1) || (be == BE_B2) || (be == BE_B3) ||
               (be == BE_H0) || (be == BE_H1) || (be == BE_W);
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// dmem_array: DEPTH_WORDS x 32 single-port RAM with per-byte write enables
// and a registered read port. Contents are never reset.
module dmem_array #(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    be_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-masked write or registered word read, one access per enabled cycle
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: target end of the core's load/store request interface.
// One request outstanding at a time; response after a fixed LATENCY.
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault misaligned
// addresses and non-naturally-aligned byte enables.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] LAT_LOAD = (LATENCY >= 2) ? 2'(LATENCY - 2) : 2'd0;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..4");
    end

    state_e      state_q, state_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        accept;
    logic        fault;
    logic [31:0] ram_rdata;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // Fault decode for the request currently presented
`ifdef DMEM_ALIGN_CHECK_EN
    assign fault = (|req_addr[31:2+AW]) || (req_addr[1:0] != 2'b00) || !be_is_legal(req_be);
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];
    assign fault = |req_addr[31:2+AW];
`endif

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .en_i    (accept),
        .we_i    (req_we && !fault),
        .addr_i  (req_addr[2 +: AW]),
        .wdata_i (req_wdata),
        .be_i    (req_be),
        .rdata_o (ram_rdata)
    );

    // State, latency counter and captured request attributes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            we_q      <= we_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic and handshake/response outputs
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        we_d      = we_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d  = req_we;
                    err_d = fault;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d   = ST_WAIT;
                        lat_cnt_d = LAT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM output register is untouched while a response is pending, so the
    // data stays stable under backpressure without a separate holding register.
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder. Three instances
// (LATENCY 1, 3 and 4) share clock, reset and request payload; each has
// its own valid/ready handshake. Honours DMEM_ALIGN_CHECK_EN.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;

    logic        req_valid_a [3];
    logic        rsp_ready_a [3];
    logic        req_ready_a [3];
    logic        rsp_valid_a [3];
    logic [31:0] rsp_rdata_a [3];
    logic        rsp_err_a   [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready_a[0]),
        .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_a[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready_a[1]),
        .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_a[1])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_a[2]), .rsp_ready(rsp_ready_a[2]),
        .rsp_rdata(rsp_rdata_a[2]), .rsp_err(rsp_err_a[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request, let it be accepted, wait (bounded) for rsp_valid.
    // lat counts falling edges after the accept edge until rsp_valid is seen.
    task automatic issue(input int idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid_a[idx] = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid_a[idx] = 1'b0;
            lat++;
        end while (!rsp_valid_a[idx] && lat < 20);
        rdata = rsp_rdata_a[idx];
        err   = rsp_err_a[idx];
    endtask

    task automatic ack(input int idx);
        rsp_ready_a[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_a[idx] = 1'b0;
    endtask

    task automatic xfer(input string tag, input int idx, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lt;
        issue(idx, we, addr, wdata, be, rd, er, lt);
        check({tag, "_lat"}, 32'(lt), 32'(exp_lat));
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_rdata"}, rd, exp_rdata);
        ack(idx);
        check({tag, "_ready_after"}, 32'(req_ready_a[idx]), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        logic        saw_valid;

        for (int i = 0; i < 3; i++) begin
            req_valid_a[i] = 1'b0;
            rsp_ready_a[i] = 1'b0;
        end

        // 1. Reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_req_ready", 32'(req_ready_a[i]), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid_a[i]), 32'd0);
            check("rst_rsp_rdata", rsp_rdata_a[i], 32'd0);
            check("rst_rsp_err",   32'(rsp_err_a[i]), 32'd0);
        end

        // 2. Write then read, LATENCY=1
        xfer("l1_wr10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 1);
        xfer("l1_rd10", 0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0, 1);

        // 3. Byte-masked write into lane 2
        xfer("l1_wrb2", 0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100, 32'h0, 1'b0, 1);
        xfer("l1_rdb2", 0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEAABEEF, 1'b0, 1);

        // Write with no byte enables is acked and changes nothing
        xfer("l1_wrbe0", 0, 1'b1, 32'h10, 32'h11223344, 4'b0000, 32'h0, 1'b0, 1);
        xfer("l1_rdbe0", 0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEAABEEF, 1'b0, 1);

        // 5. Range fault; 0x1000 would alias word 0 if not blocked
        xfer("l1_wr0",    0, 1'b1, 32'h0,   32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 1);
        xfer("l1_wrtop",  0, 1'b1, 32'hFFC, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0, 1);
        xfer("l1_rdtop",  0, 1'b0, 32'hFFC, 32'h0, 4'b1111, 32'h0BADF00D, 1'b0, 1);
        xfer("l1_wroor",  0, 1'b1, 32'h1000, 32'h11111111, 4'b1111, 32'h0, 1'b1, 1);
        xfer("l1_rdoor",  0, 1'b0, 32'h1000, 32'h0, 4'b1111, 32'h0, 1'b1, 1);
        xfer("l1_rd0",    0, 1'b0, 32'h0,   32'h0, 4'b1111, 32'hCAFEF00D, 1'b0, 1);

        // 6. Alignment / byte-enable legality
`ifdef DMEM_ALIGN_CHECK_EN
        xfer("l1_misalign", 0, 1'b0, 32'h12, 32'h0, 4'b1111, 32'h0, 1'b1, 1);
        xfer("l1_badbe",    0, 1'b0, 32'h10, 32'h0, 4'b0110, 32'h0, 1'b1, 1);
        xfer("l1_wrbadbe",  0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0110, 32'h0, 1'b1, 1);
        xfer("l1_rdafter",  0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEAABEEF, 1'b0, 1);
`else
        xfer("l1_misalign", 0, 1'b0, 32'h12, 32'h0, 4'b1111, 32'hDEAABEEF, 1'b0, 1);
        xfer("l1_badbe",    0, 1'b0, 32'h10, 32'h0, 4'b0110, 32'hDEAABEEF, 1'b0, 1);
`endif

        // 4. Backpressure, LATENCY=3
        xfer("l3_wr20", 1, 1'b1, 32'h20, 32'h12345678, 4'b1111, 32'h0, 1'b0, 3);
        issue(1, 1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lt);
        check("l3_bp_lat", 32'(lt), 32'd3);
        for (int k = 0; k < 5; k++) begin
            check("l3_bp_rdata", rsp_rdata_a[1], 32'h12345678);
            check("l3_bp_err",   32'(rsp_err_a[1]), 32'd0);
            check("l3_bp_valid", 32'(rsp_valid_a[1]), 32'd1);
            check("l3_bp_ready", 32'(req_ready_a[1]), 32'd0);
            @(negedge clk);
        end
        ack(1);
        check("l3_bp_idle_ready", 32'(req_ready_a[1]), 32'd1);
        check("l3_bp_idle_valid", 32'(rsp_valid_a[1]), 32'd0);

        // 7. Reset while in WAIT, LATENCY=4
        xfer("l4_wr10", 2, 1'b1, 32'h10, 32'h55AA55AA, 4'b1111, 32'h0, 1'b0, 4);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hA5A5A5A5; req_be = 4'b1111;
        req_valid_a[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_a[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            saw_valid |= rsp_valid_a[2];
            @(negedge clk);
        end
        check("l4_rst_no_rsp", 32'(saw_valid), 32'd0);
        check("l4_rst_ready",  32'(req_ready_a[2]), 32'd1);
        xfer("l4_rd14", 2, 1'b0, 32'h14, 32'h0, 4'b1111, 32'hA5A5A5A5, 1'b0, 4);
        xfer("l4_rd10", 2, 1'b0, 32'h10, 32'h0, 4'b1111, 32'h55AA55AA, 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
